if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, including the IF/ID pipeline register. Holds the program counter, issues fetches to instruction memory over a variable-latency req/ready handshake, and selects the next PC from the redirect information resolved in decode (`pc_src`, branch/jump targets, `flush`). Feeds the decode stage with `instruction`, `pc_out` (PC+4) and `valid`, and obeys `stall` from the hazard unit.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `flush`  in  1  decode: taken branch/jump, discard the instruction being fetched
- `pc_src`  in  2  next-PC select: 00 PC+4, 01 `branch_address`, 10 `j_address`, 11 `jr_address`
- `branch_address`, `j_address`, `jr_address`  in  32 each  redirect targets from decode
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address (= PC)
- `imem_rdata`  in  32  instruction word, valid when `imem_ready`
- `imem_ready`  in  1  memory returns data for the current `imem_addr` this cycle
- `instruction`  out  32  IF/ID instruction (NOP = 32'h0 when invalid)
- `pc_out`  out  32  IF/ID PC+4 of that instruction
- `valid`  out  1  IF/ID holds a real instruction

## Operation
- States: FETCH (`imem_req`=1, `imem_addr`=PC), HOLD (word captured in hold buffer while stalled, `imem_req`=0).
- Memory contract: `imem_addr` may change while `imem_ready`=0; the pending request is abandoned, no drain.
- Events are evaluated per cycle in priority order: rst > stall > flush > normal.
- Redirect (`flush`=1, `stall`=0), in either state: PC <- target selected by `pc_src`; IF/ID <- NOP, `valid`=0; any returning word and the hold buffer are discarded; next state FETCH.
- FETCH, `imem_ready`=1, no stall: IF/ID <- {`imem_rdata`, PC+4, 1}; PC <- PC+4.
- FETCH, `imem_ready`=1, `stall`=1: hold buffer <- {`imem_rdata`, PC+4}; PC <- PC+4; IF/ID unchanged; -> HOLD.
- FETCH, `imem_ready`=0, no stall: IF/ID <- bubble (NOP, `valid`=0); PC unchanged.
- HOLD, `stall`=1: everything held. HOLD, `stall`=0: IF/ID <- hold buffer, `valid`=1; -> FETCH.
- `stall`=1 always freezes IF/ID; `flush` is ignored while stalled (decode re-evaluates the branch).
- `pc_src` is used only when `flush`=1; otherwise the next PC is always PC+4.
- PC+4 wraps modulo 2^32; the low two PC bits are never altered by the stage.

## Timing
- Reset values: PC=`RESET_PC`, `instruction`=0, `pc_out`=0, `valid`=0, hold buffer=0, state FETCH; `imem_req`=1 from the first cycle after reset.
- Zero-wait memory (`imem_ready` tied 1): one instruction per cycle; the word at A appears on IF/ID the cycle after A is presented.
- Redirect latency: target is on `imem_addr` the cycle after `flush`; exactly one bubble is inserted.
- `rst` asserted in HOLD or mid-request drops all state and returns to FETCH at `RESET_PC`.

## Structure
- Shared package `mips_pkg`: `pc_src` encodings (PCSRC_SEQ/BR/J/JR), `NOP_INSTR`=32'h0, state enum `if_state_t`.
- One sub-module, `if_id_reg`: a 65-bit register with synchronous reset, load and clear, holding `instruction`, `pc_out` and `valid`.
- PC+4 uses the existing 32-bit adder.

## Test plan
- Reset with ready tied 1: after reset, `imem_addr` = 0, 4, 8 on consecutive cycles; `valid` rises one cycle after the first address; `pc_out` = 4.
- Wait states: ready low 2 cycles at addr 0x10 -> 2 bubbles (`valid`=0, `instruction`=0); then word at 0x10 with `pc_out`=0x14.
- Stall with ready: stall 3 cycles while word at 0x20 returns -> IF/ID frozen, `imem_req`=0; on release IF/ID shows the 0x20 word with `pc_out`=0x24; next fetch is 0x24.
- Redirect: `flush`=1, `pc_src`=01, `branch_address`=0x100, and ready=1 -> that word is dropped, IF/ID bubble, next `imem_addr`=0x100; repeat with `pc_src`=10 and 11.
- Flush while stalled (flush and stall both 1) -> ignored, PC unchanged; flush in HOLD after stall release -> hold buffer discarded, fetch from target.
- Wrap-around and reset: PC=0xFFFF_FFFC fetched -> `pc_out`=0; `rst` during HOLD -> all outputs 0, fetch at `RESET_PC` next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage and its IF/ID register.
// Holds next-PC select codes, the NOP word, FSM states and the IF/ID bundle.
package mips_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } if_state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_out;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch port: request/address out, data/ready back.
// The fetch stage is the master; the memory model is the slave.
interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: 65 bits with synchronous reset, clear and load.
// Clear wins over load so a bubble always beats an incoming word.
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  logic   i_clear,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_q <= '{instruction: NOP_INSTR, pc_out: 32'h0, valid: 1'b0};
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, variable-latency fetch, redirect, IF/ID.
// A word returning during a stall is parked in a hold buffer (HOLD).
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_address,
    input  logic [31:0] j_address,
    input  logic [31:0] jr_address,
    if_stage_if.master  imem,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        valid
);

    if_state_t   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc4;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_load;
    logic        w_clear;
    if_id_t      w_d;
    if_id_t      w_q;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_target = w_pc_plus4;
        unique case (pc_src)
            PCSRC_SEQ: w_target = w_pc_plus4;
            PCSRC_BR:  w_target = branch_address;
            PCSRC_J:   w_target = j_address;
            PCSRC_JR:  w_target = jr_address;
        endcase
    end

    // Stall freezes IF/ID; otherwise flush or a wait state yields a bubble.
    always_comb begin
        w_load  = 1'b0;
        w_clear = 1'b0;
        w_d     = '{instruction: imem.imem_rdata,
                    pc_out:      w_pc_plus4,
                    valid:       1'b1};
        if (!stall) begin
            if (flush) begin
                w_clear = 1'b1;
            end else if (r_state == HOLD) begin
                w_load = 1'b1;
                w_d    = '{instruction: r_hold_instr,
                           pc_out:      r_hold_pc4,
                           valid:       1'b1};
            end else if (imem.imem_ready) begin
                w_load = 1'b1;
            end else begin
                w_clear = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc4   <= 32'h0;
        end else if (stall) begin
            if (r_state == FETCH && imem.imem_ready) begin
                r_hold_instr <= imem.imem_rdata;
                r_hold_pc4   <= w_pc_plus4;
                r_pc         <= w_pc_plus4;
                r_state      <= HOLD;
            end
        end else if (flush) begin
            r_pc         <= w_target;
            r_state      <= FETCH;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc4   <= 32'h0;
        end else if (r_state == HOLD) begin
            r_state <= FETCH;
        end else if (imem.imem_ready) begin
            r_pc <= w_pc_plus4;
        end
    end

    assign imem.imem_req  = (r_state == FETCH);
    assign imem.imem_addr = r_pc;

    if_id_reg u_if_id (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_d     (w_d),
        .o_q     (w_q)
    );

    assign instruction = w_q.instruction;
    assign pc_out      = w_q.pc_out;
    assign valid       = w_q.valid;

endmodule
